// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - command encodings, mode-register fields and burst-length decode for the SDRAM model
package sdram_pkg;

  // Raw {ncs, ras, cas, nwe} encodings
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_READ      = 4'b0101;

  // Mode-register field positions inside sdram_address
  localparam int MODE_BL_LSB       = 0;
  localparam int MODE_CL_LSB       = 4;
  localparam int MODE_FIELD_W      = 3;
  localparam int PRECHARGE_ALL_BIT = 10;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_ACTIVE,
    OP_READ,
    OP_WRITE,
    OP_PRECHARGE,
    OP_REFRESH,
    OP_LOAD_MODE
  } sdram_op_e;

  typedef enum logic {
    BANK_IDLE,
    BANK_ACTIVE
  } bank_state_e;

  typedef struct packed {
    logic       ok;
    logic [3:0] beats;
  } bl_decode_t;

  // DESELECT and the reserved 0110 code both fold into OP_NOP
  function automatic sdram_op_e decode_cmd(input logic [3:0] cmd);
    sdram_op_e op;
    op = OP_NOP;
    case (cmd)
      CMD_LOAD_MODE: op = OP_LOAD_MODE;
      CMD_REFRESH:   op = OP_REFRESH;
      CMD_PRECHARGE: op = OP_PRECHARGE;
      CMD_ACTIVE:    op = OP_ACTIVE;
      CMD_WRITE:     op = OP_WRITE;
      CMD_READ:      op = OP_READ;
      default:       op = OP_NOP;
    endcase
    return op;
  endfunction

  // Unsupported burst codes fall back to a single beat
  function automatic bl_decode_t decode_bl(input logic [2:0] field);
    bl_decode_t r;
    case (field)
      3'd0:    r = '{ok: 1'b1, beats: 4'd1};
      3'd1:    r = '{ok: 1'b1, beats: 4'd2};
      3'd2:    r = '{ok: 1'b1, beats: 4'd4};
      3'd3:    r = '{ok: 1'b1, beats: 4'd8};
      default: r = '{ok: 1'b0, beats: 4'd1};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sdram_model_bank.sv
// rtl/sdram_model_bank.sv - per-bank open/closed state and open row; tRCD/tRP counter under SDRAM_MODEL_TIMING_CHECK_EN
module sdram_model_bank
  import sdram_pkg::*;
#(
  parameter int ADDRESS_WIDTH         = 11,
  parameter int BANK_ACTIVATE_LATENCY = 2,
  parameter int PRECHARGE_LATENCY     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     act_en,
  input  logic                     pre_en,
  input  logic [ADDRESS_WIDTH-1:0] row_in,
  output logic                     active,
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
  output logic                     ready,
`endif
  output logic [ADDRESS_WIDTH-1:0] open_row
);

  bank_state_e              state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] row_q, row_d;

  // Next bank state: ACTIVE opens a row, PRECHARGE closes it
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    if (act_en) begin
      state_d = BANK_ACTIVE;
      row_d   = row_in;
    end else if (pre_en) begin
      state_d = BANK_IDLE;
    end
  end

  // Bank state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BANK_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  assign active   = (state_q == BANK_ACTIVE);
  assign open_row = row_q;

`ifdef SDRAM_MODEL_TIMING_CHECK_EN
  // One counter serves both tRCD and tRP: a bank is only ever waiting on one of them
  localparam logic [7:0] TRCD_LOAD = 8'((BANK_ACTIVATE_LATENCY > 0) ? BANK_ACTIVATE_LATENCY - 1 : 0);
  localparam logic [7:0] TRP_LOAD  = 8'((PRECHARGE_LATENCY > 0) ? PRECHARGE_LATENCY - 1 : 0);

  logic [7:0] cnt_q, cnt_d;

  // Reload on ACTIVE/PRECHARGE, otherwise count down to zero
  always_comb begin
    cnt_d = cnt_q;
    if (act_en) begin
      cnt_d = TRCD_LOAD;
    end else if (pre_en) begin
      cnt_d = TRP_LOAD;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Timing counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ready = (cnt_q == 8'd0);
`endif

endmodule

// File: rtl/sdram_model16.sv
// rtl/sdram_model16.sv - x16 SDRAM behavioural model top; SDRAM_MODEL_TIMING_CHECK_EN adds tRCD/tRP/tRFC checks
module sdram_model16
  import sdram_pkg::*;
#(
  parameter int ADDRESS_WIDTH         = 11,
  parameter int COLUMN_ADDRESS_WIDTH  = 8,
  parameter int BANK_BITS             = 2,
  parameter int STORAGE_BITS          = 12,
  parameter int BANK_ACTIVATE_LATENCY = 2,
  parameter int PRECHARGE_LATENCY     = 2,
  parameter int AUTOREFRESH_LATENCY   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sdram_ncs,
  input  logic                     sdram_ras,
  input  logic                     sdram_cas,
  input  logic                     sdram_nwe,
  input  logic [ADDRESS_WIDTH-1:0] sdram_address,
  input  logic [BANK_BITS-1:0]     sdram_ba,
  input  logic [15:0]              sdram_data_in,
  input  logic [1:0]               sdram_dqm,
  output logic [15:0]              sdram_data_out,
  output logic                     sdram_data_noe,
  output logic                     error,
  output logic [15:0]              refresh_count
);

  localparam int NB    = 2 ** BANK_BITS;
  localparam int DEPTH = 2 ** STORAGE_BITS;
  localparam int CW    = COLUMN_ADDRESS_WIDTH;

  sdram_op_e                op;
  logic [NB-1:0]            bank_active;
  logic [ADDRESS_WIDTH-1:0] bank_row [NB];
  logic [NB-1:0]            act_en, pre_en;
  logic                     sel_active;
  bl_decode_t               bl_dec;
  logic [2:0]               cl_field;
  logic                     state_err, field_err, accept;

  logic                     mode_loaded_q, mode_loaded_d;
  logic [3:0]               bl_q, bl_d;
  logic                     cl3_q, cl3_d;
  logic                     error_q, error_d;
  logic [15:0]              refresh_count_q, refresh_count_d;

  logic [3:0]               burst_left_q, burst_left_d;
  logic                     burst_write_q, burst_write_d;
  logic [BANK_BITS-1:0]     burst_ba_q, burst_ba_d;
  logic [ADDRESS_WIDTH-1:0] burst_row_q, burst_row_d;
  logic [CW-1:0]            burst_col_q, burst_col_d;

  logic                     beat_valid, beat_write;
  logic [BANK_BITS-1:0]     beat_ba;
  logic [ADDRESS_WIDTH-1:0] beat_row;
  logic [CW-1:0]            beat_col, col_mask;
  logic [STORAGE_BITS-1:0]  beat_idx;
  logic                     mem_we;

  logic                     pipe0_valid_q, pipe0_valid_d, pipe1_valid_q, pipe1_valid_d;
  logic [STORAGE_BITS-1:0]  pipe0_idx_q, pipe0_idx_d, pipe1_idx_q, pipe1_idx_d;
  logic [15:0]              data_out_q, data_out_d;
  logic                     noe_q, noe_d;

  logic [15:0]              mem_q [DEPTH];

`ifdef SDRAM_MODEL_TIMING_CHECK_EN
  localparam logic [7:0] TRFC_LOAD = 8'((AUTOREFRESH_LATENCY > 0) ? AUTOREFRESH_LATENCY - 1 : 0);
  logic [NB-1:0] bank_ready;
  logic [7:0]    rfc_cnt_q, rfc_cnt_d;
`endif

  // Sequential burst: the column advances inside its BL-aligned block and wraps
  function automatic logic [CW-1:0] next_col(input logic [CW-1:0] c, input logic [CW-1:0] m);
    return (c & ~m) | ((c + CW'(1)) & m);
  endfunction

  assign op         = decode_cmd({sdram_ncs, sdram_ras, sdram_cas, sdram_nwe});
  assign sel_active = bank_active[sdram_ba];
  assign bl_dec     = decode_bl(sdram_address[MODE_BL_LSB +: MODE_FIELD_W]);
  assign cl_field   = sdram_address[MODE_CL_LSB +: MODE_FIELD_W];
  assign col_mask   = CW'(bl_q - 4'd1);

  for (genvar g = 0; g < NB; g++) begin : g_bank
    sdram_model_bank #(
      .ADDRESS_WIDTH        (ADDRESS_WIDTH),
      .BANK_ACTIVATE_LATENCY(BANK_ACTIVATE_LATENCY),
      .PRECHARGE_LATENCY    (PRECHARGE_LATENCY)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .act_en  (act_en[g]),
      .pre_en  (pre_en[g]),
      .row_in  (sdram_address),
      .active  (bank_active[g]),
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
      .ready   (bank_ready[g]),
`endif
      .open_row(bank_row[g])
    );
  end

  // Protocol checks; a state error blocks the command, a bad mode field only flags it
  always_comb begin
    state_err = 1'b0;
    field_err = 1'b0;
    if (op != OP_NOP && op != OP_LOAD_MODE && !mode_loaded_q) state_err = 1'b1;
    case (op)
      OP_READ, OP_WRITE: if (!sel_active) state_err = 1'b1;
      OP_ACTIVE:         if (sel_active) state_err = 1'b1;
      OP_REFRESH:        if (|bank_active) state_err = 1'b1;
      OP_LOAD_MODE: begin
        if (|bank_active) state_err = 1'b1;
        if (!bl_dec.ok || (cl_field != 3'd2 && cl_field != 3'd3)) field_err = 1'b1;
      end
      default: ;
    endcase
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
    if ((op == OP_READ || op == OP_WRITE || op == OP_ACTIVE) && !bank_ready[sdram_ba]) state_err = 1'b1;
    if (op != OP_NOP && rfc_cnt_q != 8'd0) state_err = 1'b1;
`endif
  end

  assign accept = !state_err;

  // Next-state: mode, bank strobes, burst engine, read pipeline and outputs
  always_comb begin
    mode_loaded_d   = mode_loaded_q;
    bl_d            = bl_q;
    cl3_d           = cl3_q;
    error_d         = error_q | state_err | field_err;
    refresh_count_d = refresh_count_q;
    act_en          = '0;
    pre_en          = '0;
    burst_left_d    = burst_left_q;
    burst_write_d   = burst_write_q;
    burst_ba_d      = burst_ba_q;
    burst_row_d     = burst_row_q;
    burst_col_d     = burst_col_q;
    beat_valid      = 1'b0;
    beat_write      = burst_write_q;
    beat_ba         = burst_ba_q;
    beat_row        = burst_row_q;
    beat_col        = burst_col_q;

    if (accept && op == OP_LOAD_MODE) begin
      mode_loaded_d = 1'b1;
      bl_d          = bl_dec.beats;
      cl3_d         = (cl_field == 3'd3);
    end
    if (accept && op == OP_REFRESH) refresh_count_d = refresh_count_q + 16'd1;

    for (int b = 0; b < NB; b++) begin
      act_en[b] = accept && (op == OP_ACTIVE) && (sdram_ba == BANK_BITS'(b));
      pre_en[b] = accept && (op == OP_PRECHARGE) &&
                  (sdram_address[PRECHARGE_ALL_BIT] || sdram_ba == BANK_BITS'(b));
    end

    // A new READ/WRITE restarts the burst engine; otherwise an open burst keeps stepping
    if (accept && (op == OP_READ || op == OP_WRITE)) begin
      beat_valid    = 1'b1;
      beat_write    = (op == OP_WRITE);
      beat_ba       = sdram_ba;
      beat_row      = bank_row[sdram_ba];
      beat_col      = sdram_address[CW-1:0];
      burst_write_d = beat_write;
      burst_ba_d    = beat_ba;
      burst_row_d   = beat_row;
      burst_left_d  = bl_q - 4'd1;
      burst_col_d   = next_col(beat_col, col_mask);
    end else if (burst_left_q != 4'd0) begin
      beat_valid   = 1'b1;
      burst_left_d = burst_left_q - 4'd1;
      burst_col_d  = next_col(burst_col_q, col_mask);
    end

    beat_idx = STORAGE_BITS'({beat_ba, beat_row, beat_col});
    mem_we   = beat_valid && beat_write && !reset;

    // CL3 beats enter one stage earlier than CL2 beats; both leave via stage 1
    pipe0_valid_d = beat_valid && !beat_write && cl3_q;
    pipe0_idx_d   = beat_idx;
    pipe1_valid_d = pipe0_valid_q;
    pipe1_idx_d   = pipe0_idx_q;
    if (beat_valid && !beat_write && !cl3_q) begin
      pipe1_valid_d = 1'b1;
      pipe1_idx_d   = beat_idx;
    end

    data_out_d = pipe1_valid_q ? mem_q[pipe1_idx_q] : 16'h0000;
    noe_d      = !pipe1_valid_q;
  end

`ifdef SDRAM_MODEL_TIMING_CHECK_EN
  // tRFC lockout after an accepted AUTO REFRESH
  always_comb begin
    rfc_cnt_d = rfc_cnt_q;
    if (accept && op == OP_REFRESH) begin
      rfc_cnt_d = TRFC_LOAD;
    end else if (rfc_cnt_q != 8'd0) begin
      rfc_cnt_d = rfc_cnt_q - 8'd1;
    end
  end

  // tRFC counter register
  always_ff @(posedge clk) begin
    if (reset) rfc_cnt_q <= 8'd0;
    else       rfc_cnt_q <= rfc_cnt_d;
  end
`endif

  // Control, burst and pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_loaded_q   <= 1'b0;
      bl_q            <= 4'd1;
      cl3_q           <= 1'b0;
      error_q         <= 1'b0;
      refresh_count_q <= 16'h0000;
      burst_left_q    <= 4'd0;
      burst_write_q   <= 1'b0;
      burst_ba_q      <= '0;
      burst_row_q     <= '0;
      burst_col_q     <= '0;
      pipe0_valid_q   <= 1'b0;
      pipe0_idx_q     <= '0;
      pipe1_valid_q   <= 1'b0;
      pipe1_idx_q     <= '0;
      data_out_q      <= 16'h0000;
      noe_q           <= 1'b1;
    end else begin
      mode_loaded_q   <= mode_loaded_d;
      bl_q            <= bl_d;
      cl3_q           <= cl3_d;
      error_q         <= error_d;
      refresh_count_q <= refresh_count_d;
      burst_left_q    <= burst_left_d;
      burst_write_q   <= burst_write_d;
      burst_ba_q      <= burst_ba_d;
      burst_row_q     <= burst_row_d;
      burst_col_q     <= burst_col_d;
      pipe0_valid_q   <= pipe0_valid_d;
      pipe0_idx_q     <= pipe0_idx_d;
      pipe1_valid_q   <= pipe1_valid_d;
      pipe1_idx_q     <= pipe1_idx_d;
      data_out_q      <= data_out_d;
      noe_q           <= noe_d;
    end
  end

  // Backing store: byte-masked writes, contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (!sdram_dqm[0]) mem_q[beat_idx][7:0]  <= sdram_data_in[7:0];
      if (!sdram_dqm[1]) mem_q[beat_idx][15:8] <= sdram_data_in[15:8];
    end
  end

  assign sdram_data_out = data_out_q;
  assign sdram_data_noe = noe_q;
  assign error          = error_q;
  assign refresh_count  = refresh_count_q;

endmodule

// File: tb/tb_sdram_model16.sv
// tb/tb_sdram_model16.sv - directed bench for sdram_model16
module tb_sdram_model16;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ncs, ras, cas, nwe;
  logic [10:0] addr;
  logic [1:0]  ba;
  logic [15:0] din;
  logic [1:0]  dqm;
  logic [15:0] dout;
  logic        noe;
  logic        err;
  logic [15:0] rcount;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sdram_model16 dut (
    .clk           (clk),
    .reset         (reset),
    .sdram_ncs     (ncs),
    .sdram_ras     (ras),
    .sdram_cas     (cas),
    .sdram_nwe     (nwe),
    .sdram_address (addr),
    .sdram_ba      (ba),
    .sdram_data_in (din),
    .sdram_dqm     (dqm),
    .sdram_data_out(dout),
    .sdram_data_noe(noe),
    .error         (err),
    .refresh_count (rcount)
  );

  task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [10:0] a,
                       input logic [15:0] d, input logic [1:0] m);
    {ncs, ras, cas, nwe} = c;
    ba = b; addr = a; din = d; dqm = m;
    @(negedge clk);
    {ncs, ras, cas, nwe} = C_NOP;
    dqm = 2'b00;
  endtask

  task automatic nop(input logic [15:0] d, input logic [1:0] m);
    issue(C_NOP, 2'd0, 11'd0, d, m);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (dout !== 16'h0000) begin miscompares++; $display("FAIL reset_data: got %h want 0000", dout); end
    vectors++; if (noe !== 1'b1) begin miscompares++; $display("FAIL reset_noe: got %b want 1", noe); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b want 0", err); end
    vectors++; if (rcount !== 16'h0000) begin miscompares++; $display("FAIL reset_refresh: got %h want 0000", rcount); end
    reset = 1'b0;
  endtask

  task automatic test_bl2_cl2();
    issue(C_LMR, 2'd0, 11'h021, 16'h0, 2'b00);
    issue(C_REF, 2'd0, 11'h000, 16'h0, 2'b00);
    vectors++; if (rcount !== 16'h0001) begin miscompares++; $display("FAIL refresh_count: got %h want 0001", rcount); end
    repeat (3) nop(16'h0, 2'b00);
    issue(C_ACT, 2'd0, 11'd5, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    issue(C_WR, 2'd0, 11'd0, 16'h1234, 2'b00);
    nop(16'h5678, 2'b00);
    nop(16'h0, 2'b00);
    issue(C_RD, 2'd0, 11'd0, 16'h0, 2'b00);
    vectors++; if (noe !== 1'b1) begin miscompares++; $display("FAIL bl2_noe_c1: got %b want 1", noe); end
    nop(16'h0, 2'b00);
    vectors++; if (dout !== 16'h1234 || noe !== 1'b0) begin miscompares++; $display("FAIL bl2_beat0: got %h/%b want 1234/0", dout, noe); end
    nop(16'h0, 2'b00);
    vectors++; if (dout !== 16'h5678 || noe !== 1'b0) begin miscompares++; $display("FAIL bl2_beat1: got %h/%b want 5678/0", dout, noe); end
    nop(16'h0, 2'b00);
    vectors++; if (dout !== 16'h0000 || noe !== 1'b1) begin miscompares++; $display("FAIL bl2_after: got %h/%b want 0000/1", dout, noe); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL bl2_error: got %b want 0", err); end
  endtask

  task automatic test_dqm();
    issue(C_WR, 2'd0, 11'd0, 16'hFFFF, 2'b10);
    nop(16'h0000, 2'b11);
    nop(16'h0, 2'b00);
    issue(C_RD, 2'd0, 11'd0, 16'h0, 2'b11);
    nop(16'h0, 2'b00);
    vectors++; if (dout !== 16'h12FF) begin miscompares++; $display("FAIL dqm_low_byte: got %h want 12FF", dout); end
    nop(16'h0, 2'b00);
    vectors++; if (dout !== 16'h5678) begin miscompares++; $display("FAIL dqm_full_mask: got %h want 5678", dout); end
    nop(16'h0, 2'b00);
  endtask

  task automatic test_bl4_cl3_wrap();
    logic [15:0] exp [4];
    exp[0] = 16'hCCCC; exp[1] = 16'hDDDD; exp[2] = 16'hAAAA; exp[3] = 16'hBBBB;
    issue(C_PRE, 2'd0, 11'h400, 16'h0, 2'b00);
    issue(C_LMR, 2'd0, 11'h032, 16'h0, 2'b00);
    issue(C_ACT, 2'd0, 11'd5, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    issue(C_WR, 2'd0, 11'd6, 16'hAAAA, 2'b00);
    nop(16'hBBBB, 2'b00);
    nop(16'hCCCC, 2'b00);
    nop(16'hDDDD, 2'b00);
    nop(16'h0, 2'b00);
    issue(C_RD, 2'd0, 11'd4, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    vectors++; if (noe !== 1'b1) begin miscompares++; $display("FAIL cl3_noe_c2: got %b want 1", noe); end
    for (int i = 0; i < 4; i++) begin
      nop(16'h0, 2'b00);
      vectors++; if (dout !== exp[i] || noe !== 1'b0) begin miscompares++; $display("FAIL bl4_beat%0d: got %h/%b want %h/0", i, dout, noe, exp[i]); end
    end
    nop(16'h0, 2'b00);
    vectors++; if (noe !== 1'b1) begin miscompares++; $display("FAIL bl4_after: got %b want 1", noe); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [4];
    exp[0] = 16'h3333; exp[1] = 16'h4444; exp[2] = 16'h1111; exp[3] = 16'h2222;
    issue(C_RD, 2'd0, 11'd4, 16'h0, 2'b00);
    issue(C_WR, 2'd0, 11'd0, 16'h1111, 2'b00);
    nop(16'h2222, 2'b00);
    vectors++; if (dout !== 16'hCCCC || noe !== 1'b0) begin miscompares++; $display("FAIL trunc_due_beat: got %h/%b want CCCC/0", dout, noe); end
    nop(16'h3333, 2'b00);
    vectors++; if (noe !== 1'b1) begin miscompares++; $display("FAIL trunc_cut: got %b want 1", noe); end
    nop(16'h4444, 2'b00);
    nop(16'h0, 2'b00);
    issue(C_RD, 2'd0, 11'd2, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      nop(16'h0, 2'b00);
      vectors++; if (dout !== exp[i]) begin miscompares++; $display("FAIL rewrite_beat%0d: got %h want %h", i, dout, exp[i]); end
    end
    nop(16'h0, 2'b00);
  endtask

  task automatic test_idle_bank_error();
    issue(C_RD, 2'd1, 11'd0, 16'h0, 2'b00);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL idle_read_error: got %b want 1", err); end
    for (int i = 0; i < 4; i++) begin
      nop(16'h0, 2'b00);
      vectors++; if (noe !== 1'b1) begin miscompares++; $display("FAIL idle_read_noe%0d: got %b want 1", i, noe); end
    end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL error_sticky: got %b want 1", err); end
  endtask

  task automatic test_no_mode();
    pulse_reset();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL no_mode_clear: got %b want 0", err); end
    issue(C_ACT, 2'd0, 11'd5, 16'h0, 2'b00);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL no_mode_error: got %b want 1", err); end
  endtask

  task automatic test_reset_mid_burst();
    pulse_reset();
    issue(C_LMR, 2'd0, 11'h033, 16'h0, 2'b00);
    issue(C_ACT, 2'd0, 11'd5, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    issue(C_RD, 2'd0, 11'd0, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    nop(16'h0, 2'b00);
    vectors++; if (dout !== 16'h1111 || noe !== 1'b0) begin miscompares++; $display("FAIL bl8_beat0: got %h/%b want 1111/0", dout, noe); end
    nop(16'h0, 2'b00);
    vectors++; if (dout !== 16'h2222) begin miscompares++; $display("FAIL bl8_beat1: got %h want 2222", dout); end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (noe !== 1'b1) begin miscompares++; $display("FAIL midreset_noe: got %b want 1", noe); end
    vectors++; if (dout !== 16'h0000) begin miscompares++; $display("FAIL midreset_data: got %h want 0000", dout); end
    vectors++; if (rcount !== 16'h0000) begin miscompares++; $display("FAIL midreset_refresh: got %h want 0000", rcount); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL midreset_error: got %b want 0", err); end
    reset = 1'b0;
    nop(16'h0, 2'b00);
    vectors++; if (noe !== 1'b1) begin miscompares++; $display("FAIL midreset_pipe_flushed: got %b want 1", noe); end
    issue(C_LMR, 2'd0, 11'h021, 16'h0, 2'b00);
    issue(C_ACT, 2'd0, 11'd5, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    issue(C_RD, 2'd0, 11'd6, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    vectors++; if (dout !== 16'hAAAA) begin miscompares++; $display("FAIL retained_beat0: got %h want AAAA", dout); end
    nop(16'h0, 2'b00);
    vectors++; if (dout !== 16'hBBBB) begin miscompares++; $display("FAIL retained_beat1: got %h want BBBB", dout); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL retained_error: got %b want 0", err); end
  endtask

  task automatic test_trcd();
    logic exp_early;
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
    exp_early = 1'b1;
`else
    exp_early = 1'b0;
`endif
    issue(C_ACT, 2'd2, 11'd1, 16'h0, 2'b00);
    issue(C_RD, 2'd2, 11'd0, 16'h0, 2'b00);
    vectors++; if (err !== exp_early) begin miscompares++; $display("FAIL trcd_1cycle: got %b want %b", err, exp_early); end
    pulse_reset();
    issue(C_LMR, 2'd0, 11'h021, 16'h0, 2'b00);
    issue(C_ACT, 2'd2, 11'd1, 16'h0, 2'b00);
    nop(16'h0, 2'b00);
    issue(C_RD, 2'd2, 11'd0, 16'h0, 2'b00);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL trcd_2cycle: got %b want 0", err); end
    repeat (4) nop(16'h0, 2'b00);
  endtask

  initial begin
    reset = 1'b1;
    {ncs, ras, cas, nwe} = C_NOP;
    addr = '0; ba = '0; din = '0; dqm = '0;
    @(negedge clk);
    test_reset();
    test_bl2_cl2();
    test_dqm();
    test_bl4_cl3_wrap();
    test_back_to_back();
    test_idle_bank_error();
    test_no_mode();
    test_reset_mid_burst();
    test_trcd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
